seq_pattern_tx: RTL
===================

// Module: seq_pattern_tx
// PURPOSE
//   Serial pattern transmitter. Accepts a parallel pattern and a repeat count over a
//   valid/ready handshake and shifts it out MSB-first, one bit per clk, on a serial line.
//   It is the driving end for the serial sequence detectors (e.g. "1010"): it produces
//   their x stream in benches and in on-chip self-test.
// PARAMETERS
//   PAT_W    4   pattern width in bits (>=2)
//   REP_W    4   width of repeat-count field
//   GAP_CYC  0   idle cycles inserted between repetitions (0 = back-to-back)
//   IDLE_LVL 1'b0 level driven on ser_out whenever ser_valid=0
// PORTS
//   clk          in   1      clock, all logic on posedge
//   rst          in   1      asynchronous, active-high reset
//   req_valid    in   1      request present
//   req_ready    out  1      block can accept request (IDLE only)
//   req_pattern  in   PAT_W  pattern, bit PAT_W-1 transmitted first
//   req_reps     in   REP_W  number of pattern repetitions
//   abort        in   1      synchronous abort of current frame
//   ser_out      out  1      serial data bit
//   ser_valid    out  1      ser_out carries a pattern/parity bit this cycle
//   busy         out  1      frame in progress (not IDLE)
//   done         out  1      one-cycle pulse: frame completed normally
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-high. All outputs registered.
//   - Reset (any time, incl. mid-frame): state=IDLE, req_ready=0, ser_valid=0,
//     ser_out=IDLE_LVL, busy=0, done=0, counters=0. req_ready rises on first edge after release.
//   - FSM: IDLE -> SHIFT [-> PARITY] [-> GAP -> SHIFT ...] -> DONE -> IDLE.
//   - Accept on edge where req_valid && req_ready; req_pattern/req_reps captured then;
//     later input changes ignored until next IDLE. req_ready=0 from that edge until DONE exits.
//   - Latency: first bit (pattern MSB) valid in the cycle immediately after acceptance;
//     one bit per cycle, no stalls; ser_valid=1 for every pattern/parity bit.
//   - Bit counter counts PAT_W-1 down to 0; at 0 with reps left: GAP for GAP_CYC cycles
//     (skipped if GAP_CYC=0), ser_valid=0, ser_out=IDLE_LVL, then next repetition.
//   - After last bit of last repetition: no gap; DONE for one cycle with done=1,
//     ser_valid=0; then IDLE, req_ready=1.
//   - Frame length = reps*(PAT_W+P) + (reps-1)*GAP_CYC cycles (P=1 with parity, else 0).
//   - req_reps=0: no bits emitted; SHIFT skipped, DONE (done=1) the cycle after acceptance.
//   - abort: highest priority after rst; any non-IDLE state -> IDLE on next edge,
//     ser_valid=0, done stays 0, req_ready=1 following edge. abort in IDLE: no effect.
//   - Simultaneous req_valid and abort in IDLE: abort ignored, request accepted.
//   - Repetition counter saturating decrement; no wrap.
// CONFIGURATION
//   SEQ_TX_PARITY_EN defined: after each PAT_W bits a PARITY state emits one even-parity
//     bit (XOR of the pattern) with ser_valid=1, before any gap.
//   Not defined: no PARITY state, no parity logic; frames are pattern bits only.
// STRUCTURE
//   Package seq_pkg: FSM state enum typedef (IDLE, SHIFT, PARITY, GAP, DONE), IDLE_LVL default,
//   shared with the detector family.
//   Sub-module seq_shift_reg: parallel-load, MSB-first shift register with bit-down-counter
//   and last-bit flag; FSM, repeat/gap counters and handshake stay in top.
// TESTING
//   1 rst=1 mid-frame of 1010 -> ser_valid=0, ser_out=0, busy=0, done=0 at once; req_ready=1
//     first edge after release.
//   2 pattern 4'b1010, reps=1, GAP_CYC=0 -> ser_out 1,0,1,0 on four consecutive valid cycles;
//     done=1 in 5th cycle; req_ready=1 in 6th; detector fires once.
//   3 1010, reps=3, GAP_CYC=2 -> 1010,gap,gap,1010,gap,gap,1010; ser_valid=0 exactly 4 cycles;
//     16 cycles total; done once.
//   4 reps=0 -> ser_valid never 1; done pulse cycle after accept. req_valid held high
//     with new pattern mid-frame -> ignored, second request accepted only after DONE.
//   5 abort at 2nd bit of 1010 -> ser_valid=0 next cycle, done never 1, req_ready=1 after.
//   6 SEQ_TX_PARITY_EN, pattern 1011 reps=1 -> 1,0,1,1,1 then done; without macro -> 1,0,1,1.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared FSM state type and idle level for the serial sequence family
package seq_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHIFT  = 3'd1,
        PARITY = 3'd2,
        GAP    = 3'd3,
        DONE   = 3'd4
    } seq_state_e;

    localparam logic SEQ_IDLE_LVL = 1'b0;

endpackage

// File: rtl/seq_pattern_tx_if.sv
// rtl/seq_pattern_tx_if.sv - request handshake and serial output bundle of seq_pattern_tx
interface seq_pattern_tx_if #(
    parameter int PAT_W = 4,
    parameter int REP_W = 4
);
    logic             req_valid;
    logic             req_ready;
    logic [PAT_W-1:0] req_pattern;
    logic [REP_W-1:0] req_reps;
    logic             abort;
    logic             ser_out;
    logic             ser_valid;
    logic             busy;
    logic             done;

    modport master (
        output req_valid, req_pattern, req_reps, abort,
        input  req_ready, ser_out, ser_valid, busy, done
    );

    modport slave (
        input  req_valid, req_pattern, req_reps, abort,
        output req_ready, ser_out, ser_valid, busy, done
    );
endinterface

// File: rtl/seq_shift_reg.sv
// rtl/seq_shift_reg.sv - parallel-load MSB-first shift register with bit down-counter and last-bit flag
module seq_shift_reg #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] pattern,
    output logic             next_bit,
    output logic             last
);
    localparam int CNT_W = $clog2(PAT_W);

    // rem holds the bits still to come after the one currently on the line
    logic [PAT_W-1:0] rem;
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem <= '0;
            cnt <= '0;
        end else if (load) begin
            rem <= pattern << 1;
            cnt <= CNT_W'(PAT_W - 1);
        end else if (shift) begin
            rem <= rem << 1;
            cnt <= (cnt == '0) ? '0 : cnt - 1'b1;
        end
    end

    assign next_bit = load ? pattern[PAT_W-1] : rem[PAT_W-1];
    assign last     = (cnt == '0);
endmodule

// File: rtl/seq_pattern_tx.sv
// rtl/seq_pattern_tx.sv - serial pattern transmitter; SEQ_TX_PARITY_EN adds an even-parity bit per repetition
module seq_pattern_tx
    import seq_pkg::*;
#(
    parameter int   PAT_W    = 4,
    parameter int   REP_W    = 4,
    parameter int   GAP_CYC  = 0,
    parameter logic IDLE_LVL = SEQ_IDLE_LVL
) (
    input logic             clk,
    input logic             rst,
    seq_pattern_tx_if.slave bus
);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);

    seq_state_e       state, nxt;
    logic [PAT_W-1:0] pat_q, load_pat;
    logic [REP_W-1:0] reps_left;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept, load, shift, rep_end, rep_dec, gap_ld;
    logic             sr_next_bit, sr_last, ser_nxt;
    logic             ready_q, busy_q, done_q, valid_q, ser_q;

    seq_shift_reg #(.PAT_W(PAT_W)) u_shift (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .shift    (shift),
        .pattern  (load_pat),
        .next_bit (sr_next_bit),
        .last     (sr_last)
    );

    always_comb begin
        nxt      = state;
        accept   = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        rep_end  = 1'b0;
        rep_dec  = 1'b0;
        gap_ld   = 1'b0;
        load_pat = pat_q;
        case (state)
            IDLE: begin
                if (bus.req_valid && ready_q) begin
                    accept = 1'b1;
                    if (bus.req_reps == '0) begin
                        nxt = DONE;
                    end else begin
                        nxt      = SHIFT;
                        load     = 1'b1;
                        load_pat = bus.req_pattern;
                    end
                end
            end
            SHIFT: begin
                if (!sr_last) begin
                    shift = 1'b1;
                end else begin
`ifdef SEQ_TX_PARITY_EN
                    nxt = PARITY;
`else
                    rep_end = 1'b1;
`endif
                end
            end
`ifdef SEQ_TX_PARITY_EN
            PARITY: rep_end = 1'b1;
`endif
            GAP: begin
                if (gap_cnt == '0) begin
                    nxt  = SHIFT;
                    load = 1'b1;
                end
            end
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase

        if (rep_end) begin
            if (reps_left == '0) begin
                nxt = DONE;
            end else begin
                rep_dec = 1'b1;
                if (GAP_CYC == 0) begin
                    nxt  = SHIFT;
                    load = 1'b1;
                end else begin
                    nxt    = GAP;
                    gap_ld = 1'b1;
                end
            end
        end

        // abort wins over everything except reset; IDLE requests are never aborted
        if (bus.abort && state != IDLE) begin
            nxt     = IDLE;
            load    = 1'b0;
            shift   = 1'b0;
            rep_dec = 1'b0;
            gap_ld  = 1'b0;
        end
    end

    always_comb begin
        ser_nxt = IDLE_LVL;
        case (nxt)
            SHIFT:   ser_nxt = sr_next_bit;
`ifdef SEQ_TX_PARITY_EN
            PARITY:  ser_nxt = ^pat_q;
`endif
            default: ser_nxt = IDLE_LVL;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            pat_q     <= '0;
            reps_left <= '0;
            gap_cnt   <= '0;
            ready_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            valid_q   <= 1'b0;
            ser_q     <= IDLE_LVL;
        end else begin
            state <= nxt;
            if (accept) begin
                pat_q     <= bus.req_pattern;
                reps_left <= (bus.req_reps == '0) ? '0 : bus.req_reps - 1'b1;
            end else if (rep_dec) begin
                reps_left <= (reps_left == '0) ? '0 : reps_left - 1'b1;
            end
            if (gap_ld) begin
                gap_cnt <= GAP_LAST;
            end else if (state == GAP && gap_cnt != '0) begin
                gap_cnt <= gap_cnt - 1'b1;
            end
            ready_q <= (nxt == IDLE);
            busy_q  <= (nxt != IDLE);
            done_q  <= (nxt == DONE);
`ifdef SEQ_TX_PARITY_EN
            valid_q <= (nxt == SHIFT) || (nxt == PARITY);
`else
            valid_q <= (nxt == SHIFT);
`endif
            ser_q   <= ser_nxt;
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.ser_valid = valid_q;
    assign bus.ser_out   = ser_q;
endmodule
